seq_add_sub_unit: RTL and testbench



---
 rtl/seq_add_sub_unit.sv | 221 ++++++++++++++++++++++
 tb/tb_seq_add_sub_unit.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_add_sub_unit.sv
// ---------------------------------------------------------------------------
// seq_add_sub_unit
//
// Multi-cycle WIDTH-bit adder/subtractor. Operands are consumed DIGIT bits
// per clock, least significant digit first, with the ripple carry held in a
// register between steps. One operation takes STEPS = WIDTH/DIGIT RUN cycles
// followed by a single DONE cycle. DONE can accept the next operation
// directly, so throughput is one operation per STEPS+1 cycles.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous, active-low reset
//   start     request; operands are sampled on the accepting edge
//             (in IDLE or DONE)
//   A, B      WIDTH-bit operands (unsigned or two's complement)
//   subtract  0: A+B, 1: A-B
//   busy      high while the unit is computing (RUN)
//   done      one-cycle pulse (DONE); Result and flags are valid from here
//   Result    sum or difference modulo 2^WIDTH
//   Cout      carry out of the MSB; for subtract 1 means no borrow
//   Overflow  signed overflow
//   Zero      Result == 0
//
// Result and the flags change only on the final RUN edge. They hold their
// last value through IDLE and through the following RUN, so partial sums
// are never visible.
// ---------------------------------------------------------------------------
module seq_add_sub_unit #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             subtract,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             Cout,
    output logic             Overflow,
    output logic             Zero
);

    localparam int STEPS = WIDTH / DIGIT;
    // A one-step configuration still needs a counter that is one bit wide.
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    // Reject parameter combinations that cannot be built.
    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("seq_add_sub_unit: WIDTH must be at least 2");
        end
        if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
            $error("seq_add_sub_unit: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t             state_reg,  state_next;
    logic [WIDTH-1:0]   opa_reg,    opa_next;
    logic [WIDTH-1:0]   opb_reg,    opb_next;
    logic [WIDTH-1:0]   acc_reg,    acc_next;
    logic               carry_reg,  carry_next;
    logic [CNT_W-1:0]   cnt_reg,    cnt_next;
    logic [WIDTH-1:0]   result_reg, result_next;
    logic               cout_reg,   cout_next;
    logic               ovf_reg,    ovf_next;
    logic               zero_reg,   zero_next;

    // ------------------------------------------------------------------
    // One-digit ripple adder on the low DIGIT bits of the operand shifters
    // ------------------------------------------------------------------
    logic [DIGIT:0]     chain;      // chain[i] = carry into bit i of the digit
    logic [DIGIT-1:0]   digit_sum;
    logic               digit_cout;
    logic               msb_cin;    // carry into the top bit of this digit
    logic [WIDTH-1:0]   acc_shift;  // accumulator with this digit inserted
    logic               last_step;

    assign chain[0] = carry_reg;

    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_ripple
            assign digit_sum[gi] = opa_reg[gi] ^ opb_reg[gi] ^ chain[gi];
            assign chain[gi+1]   = (opa_reg[gi] & opb_reg[gi])
                                 | (chain[gi] & (opa_reg[gi] ^ opb_reg[gi]));
        end
    endgenerate

    assign digit_cout = chain[DIGIT];
    // On the final step the top bit of this digit is the word MSB, so this
    // is the carry into the MSB used for signed overflow.
    assign msb_cin    = chain[DIGIT-1];

    // The sum is assembled from the top: each new digit enters at the MSB
    // end and earlier digits move down, so after STEPS digits the first
    // (least significant) digit has reached bit 0.
    generate
        if (WIDTH > DIGIT) begin : g_acc_wide
            assign acc_shift = {digit_sum, acc_reg[WIDTH-1:DIGIT]};
        end else begin : g_acc_single
            assign acc_shift = digit_sum;
        end
    endgenerate

    assign last_step = (cnt_reg == CNT_W'(STEPS - 1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            opa_reg    <= '0;
            opb_reg    <= '0;
            acc_reg    <= '0;
            carry_reg  <= 1'b0;
            cnt_reg    <= '0;
            result_reg <= '0;
            cout_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
            zero_reg   <= 1'b1;
        end else begin
            state_reg  <= state_next;
            opa_reg    <= opa_next;
            opb_reg    <= opb_next;
            acc_reg    <= acc_next;
            carry_reg  <= carry_next;
            cnt_reg    <= cnt_next;
            result_reg <= result_next;
            cout_reg   <= cout_next;
            ovf_reg    <= ovf_next;
            zero_reg   <= zero_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state, datapath and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        opa_next    = opa_reg;
        opb_next    = opb_reg;
        acc_next    = acc_reg;
        carry_next  = carry_reg;
        cnt_next    = cnt_reg;
        result_next = result_reg;
        cout_next   = cout_reg;
        ovf_next    = ovf_reg;
        zero_next   = zero_reg;
        busy        = 1'b0;
        done        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    // Subtraction is A + ~B + 1: invert B here and seed
                    // the carry with the +1.
                    opa_next   = A;
                    opb_next   = subtract ? ~B : B;
                    carry_next = subtract;
                    acc_next   = '0;
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end

            RUN: begin
                busy       = 1'b1;
                opa_next   = opa_reg >> DIGIT;
                opb_next   = opb_reg >> DIGIT;
                acc_next   = acc_shift;
                carry_next = digit_cout;
                cnt_next   = cnt_reg + 1'b1;
                if (last_step) begin
                    result_next = acc_shift;
                    cout_next   = digit_cout;
                    ovf_next    = msb_cin ^ digit_cout;
                    zero_next   = (acc_shift == '0);
                    cnt_next    = '0;
                    state_next  = DONE;
                end
            end

            DONE: begin
                done = 1'b1;
                if (start) begin
                    // Back-to-back accept, identical to the IDLE path.
                    opa_next   = A;
                    opb_next   = subtract ? ~B : B;
                    carry_next = subtract;
                    acc_next   = '0;
                    cnt_next   = '0;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign Result   = result_reg;
    assign Cout     = cout_reg;
    assign Overflow = ovf_reg;
    assign Zero     = zero_reg;

endmodule

// File: tb/tb_seq_add_sub_unit.sv
// ---------------------------------------------------------------------------
// tb_seq_add_sub_unit
//
// Directed bench for seq_add_sub_unit. One instance is built with
// WIDTH=8/DIGIT=1 and a second with WIDTH=16/DIGIT=4; both share clock and
// reset. Expected values are hand-computed for the 8-bit cases and taken
// from a small arithmetic model for the 16-bit corner sweep.
// ---------------------------------------------------------------------------
module tb_seq_add_sub_unit;

    logic       clk;
    logic       rst_n;

    // 8-bit, 1 bit per cycle instance
    logic       start;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       sub;
    logic       busy;
    logic       done;
    logic [7:0] res8;
    logic       cout8;
    logic       ovf8;
    logic       zero8;

    // 16-bit, 4 bits per cycle instance
    logic        start16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        sub16;
    logic        busy16;
    logic        done16;
    logic [15:0] res16;
    logic        cout16;
    logic        ovf16;
    logic        zero16;

    int n_checks;
    int n_fail;

    seq_add_sub_unit #(.WIDTH(8), .DIGIT(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .A        (a8),
        .B        (b8),
        .subtract (sub),
        .busy     (busy),
        .done     (done),
        .Result   (res8),
        .Cout     (cout8),
        .Overflow (ovf8),
        .Zero     (zero8)
    );

    seq_add_sub_unit #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start16),
        .A        (a16),
        .B        (b16),
        .subtract (sub16),
        .busy     (busy16),
        .done     (done16),
        .Result   (res16),
        .Cout     (cout16),
        .Overflow (ovf16),
        .Zero     (zero16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one 8-bit operation from the current cycle and wait for done.
    // Returns with the bench sitting 1 time unit after the edge that
    // raised done. Operand inputs are scrambled after the accept edge so a
    // design that fails to latch them produces wrong results.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       output int lat, output int busy_cnt,
                       output bit early, output bit timeout);
        logic [7:0] r0;
        r0       = res8;
        a8       = a;
        b8       = b;
        sub      = s;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        a8       = ~a;
        b8       = ~b;
        sub      = ~s;
        lat      = 0;
        busy_cnt = busy ? 1 : 0;
        early    = 1'b0;
        timeout  = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat     = k;
                timeout = 1'b0;
                break;
            end
            if (busy) busy_cnt++;
            if (res8 !== r0) early = 1'b1;
        end
        $display("op8 a=%02h b=%02h sub=%0d -> res=%02h cout=%0d ovf=%0d zero=%0d lat=%0d",
                 a, b, s, res8, cout8, ovf8, zero8, lat);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        start   = 1'b0;
        a8      = 8'h00;
        b8      = 8'h00;
        sub     = 1'b0;
        start16 = 1'b0;
        a16     = 16'h0000;
        b16     = 16'h0000;
        sub16   = 1'b0;
        #23;
        n_checks++;
        if ({busy, done, res8, cout8, ovf8, zero8} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state8: got busy=%b done=%b res=%02h cout=%b ovf=%b zero=%b, want 0 0 00 0 0 1",
                     busy, done, res8, cout8, ovf8, zero8);
        end
        n_checks++;
        if ({busy16, done16, res16, cout16, ovf16, zero16} !== {1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state16: got busy=%b done=%b res=%04h cout=%b ovf=%b zero=%b, want 0 0 0000 0 0 1",
                     busy16, done16, res16, cout16, ovf16, zero16);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_add();
        int lat, bc;
        bit early, to;
        op8(8'd100, 8'd27, 1'b0, lat, bc, early, to);
        n_checks++;
        if (to) begin
            n_fail++;
            $display("FAIL add_timeout: got no done within 30 cycles, want done");
        end
        n_checks++;
        if (lat !== 8) begin
            n_fail++;
            $display("FAIL add_latency: got %0d, want 8", lat);
        end
        n_checks++;
        if (bc !== 8) begin
            n_fail++;
            $display("FAIL add_busy_cycles: got %0d, want 8", bc);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL add_busy_at_done: got %b, want 0", busy);
        end
        n_checks++;
        if (early) begin
            n_fail++;
            $display("FAIL add_result_hold: got Result change before done, want hold");
        end
        n_checks++;
        if ({res8, cout8, ovf8, zero8} !== {8'd127, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL add_100_27: got res=%02h cout=%b ovf=%b zero=%b, want 7f 0 0 0",
                     res8, cout8, ovf8, zero8);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_single_pulse: got done=%b busy=%b, want 0 0", done, busy);
        end
        n_checks++;
        if (res8 !== 8'd127) begin
            n_fail++;
            $display("FAIL result_hold_idle: got %02h, want 7f", res8);
        end
    endtask

    task automatic test_overflow();
        int lat, bc;
        bit early, to;
        op8(8'd127, 8'd1, 1'b0, lat, bc, early, to);
        n_checks++;
        if (to || lat !== 8) begin
            n_fail++;
            $display("FAIL ovf_latency: got %0d (timeout=%0d), want 8", lat, to);
        end
        n_checks++;
        if ({res8, cout8, ovf8, zero8} !== {8'h80, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL add_127_1: got res=%02h cout=%b ovf=%b zero=%b, want 80 0 1 0",
                     res8, cout8, ovf8, zero8);
        end
        op8(8'hFF, 8'h01, 1'b0, lat, bc, early, to);
        n_checks++;
        if ({res8, cout8, ovf8, zero8} !== {8'h00, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL add_ff_1: got res=%02h cout=%b ovf=%b zero=%b, want 00 1 0 1",
                     res8, cout8, ovf8, zero8);
        end
        n_checks++;
        if (early) begin
            n_fail++;
            $display("FAIL ovf_result_hold: got Result change before done, want hold");
        end
    endtask

    task automatic test_subtract();
        int lat, bc;
        bit early, to;
        op8(8'd5, 8'd7, 1'b1, lat, bc, early, to);
        n_checks++;
        if ({res8, cout8, ovf8, zero8} !== {8'hFE, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_5_7: got res=%02h cout=%b ovf=%b zero=%b, want fe 0 0 0",
                     res8, cout8, ovf8, zero8);
        end
        op8(8'd9, 8'd9, 1'b1, lat, bc, early, to);
        n_checks++;
        if ({res8, cout8, ovf8, zero8} !== {8'h00, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL sub_9_9: got res=%02h cout=%b ovf=%b zero=%b, want 00 1 0 1",
                     res8, cout8, ovf8, zero8);
        end
        op8(8'h80, 8'h01, 1'b1, lat, bc, early, to);
        n_checks++;
        if ({res8, cout8, ovf8, zero8} !== {8'h7F, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_80_1: got res=%02h cout=%b ovf=%b zero=%b, want 7f 1 1 0",
                     res8, cout8, ovf8, zero8);
        end
        n_checks++;
        if (to || lat !== 8) begin
            n_fail++;
            $display("FAIL sub_latency: got %0d (timeout=%0d), want 8", lat, to);
        end
    endtask

    // start held high throughout; new operands are presented only in DONE
    // cycles, random junk otherwise.
    task automatic test_back_to_back();
        logic [7:0] ea [3];
        logic [7:0] eb [3];
        logic       es [3];
        logic [7:0] er [3];
        logic       ec [3];
        logic [7:0] hold;
        int idx, last;
        ea = '{8'd10, 8'd200, 8'd50};
        eb = '{8'd20, 8'd100, 8'd60};
        es = '{1'b0, 1'b1, 1'b1};
        er = '{8'd30, 8'd100, 8'hF6};
        ec = '{1'b0, 1'b1, 1'b0};
        @(posedge clk);
        #1;
        hold  = res8;
        idx   = 0;
        last  = 0;
        a8    = ea[0];
        b8    = eb[0];
        sub   = es[0];
        start = 1'b1;
        for (int cyc = 1; cyc <= 40 && idx < 3; cyc++) begin
            @(posedge clk);
            #1;
            if (done) begin
                $display("b2b op%0d res=%02h cout=%0d at cycle %0d", idx, res8, cout8, cyc);
                n_checks++;
                if (res8 !== er[idx] || cout8 !== ec[idx]) begin
                    n_fail++;
                    $display("FAIL b2b_result%0d: got res=%02h cout=%b, want %02h %b",
                             idx, res8, cout8, er[idx], ec[idx]);
                end
                n_checks++;
                if (cyc - last !== 9) begin
                    n_fail++;
                    $display("FAIL b2b_spacing%0d: got %0d cycles, want 9", idx, cyc - last);
                end
                last = cyc;
                hold = res8;
                idx++;
                if (idx < 3) begin
                    a8  = ea[idx];
                    b8  = eb[idx];
                    sub = es[idx];
                end else begin
                    start = 1'b0;
                end
            end else begin
                n_checks++;
                if (res8 !== hold) begin
                    n_fail++;
                    $display("FAIL b2b_hold: got %02h at cycle %0d, want %02h", res8, cyc, hold);
                end
                a8  = 8'($urandom);
                b8  = 8'($urandom);
                sub = 1'($urandom);
            end
        end
        start = 1'b0;
        n_checks++;
        if (idx !== 3) begin
            n_fail++;
            $display("FAIL b2b_timeout: got %0d done pulses, want 3", idx);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset();
        int lat, bc, ndone;
        bit early, to;
        // Make sure Result is nonzero before the reset so clearing is visible.
        op8(8'd3, 8'd4, 1'b0, lat, bc, early, to);
        a8    = 8'd50;
        b8    = 8'd50;
        sub   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        $display("async reset mid-RUN res=%02h busy=%0d", res8, busy);
        n_checks++;
        if ({busy, done, res8, cout8, ovf8, zero8} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL async_reset: got busy=%b done=%b res=%02h cout=%b ovf=%b zero=%b, want 0 0 00 0 0 1",
                     busy, done, res8, cout8, ovf8, zero8);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        n_checks++;
        if (ndone !== 0) begin
            n_fail++;
            $display("FAIL no_done_after_reset: got %0d busy/done cycles, want 0", ndone);
        end
        op8(8'd200, 8'd100, 1'b1, lat, bc, early, to);
        n_checks++;
        if (to || lat !== 8 || {res8, cout8, ovf8, zero8} !== {8'd100, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL post_reset_sub: got res=%02h cout=%b ovf=%b zero=%b lat=%0d, want 64 1 1 0 lat 8",
                     res8, cout8, ovf8, zero8, lat);
        end
    endtask

    task automatic test_wide_sweep();
        logic [15:0] v [5];
        logic [16:0] s17;
        logic        eovf;
        int lat;
        v = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                for (int s = 0; s < 2; s++) begin
                    if (s == 1) begin
                        s17  = {1'b0, v[i]} + {1'b0, ~v[j]} + 17'd1;
                        eovf = (v[i][15] != v[j][15]) && (s17[15] != v[i][15]);
                    end else begin
                        s17  = {1'b0, v[i]} + {1'b0, v[j]};
                        eovf = (v[i][15] == v[j][15]) && (s17[15] != v[i][15]);
                    end
                    a16     = v[i];
                    b16     = v[j];
                    sub16   = 1'(s);
                    start16 = 1'b1;
                    @(posedge clk);
                    #1;
                    start16 = 1'b0;
                    a16     = 16'($urandom);
                    b16     = 16'($urandom);
                    lat     = 0;
                    for (int k = 1; k <= 12; k++) begin
                        @(posedge clk);
                        #1;
                        if (done16) begin
                            lat = k;
                            break;
                        end
                    end
                    $display("op16 a=%04h b=%04h sub=%0d -> res=%04h cout=%0d ovf=%0d lat=%0d",
                             v[i], v[j], s, res16, cout16, ovf16, lat);
                    n_checks++;
                    if (lat !== 4) begin
                        n_fail++;
                        $display("FAIL w16_latency: got %0d, want 4", lat);
                    end
                    n_checks++;
                    if ({res16, cout16, ovf16, zero16} !== {s17[15:0], s17[16], eovf, (s17[15:0] == 16'h0)}) begin
                        n_fail++;
                        $display("FAIL w16_result a=%04h b=%04h sub=%0d: got res=%04h cout=%b ovf=%b zero=%b, want %04h %b %b %b",
                                 v[i], v[j], s, res16, cout16, ovf16, zero16,
                                 s17[15:0], s17[16], eovf, (s17[15:0] == 16'h0));
                    end
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_add();
        test_overflow();
        test_subtract();
        test_back_to_back();
        test_async_reset();
        test_wide_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
